// File: rtl/fd_reg_flushctl.sv
// Fetch/decode pipeline register with stall, jump/redirect squash and an optional
// post-jump shadow window; counts squashed valid fetch slots for performance monitoring.
module fd_reg_flushctl #(
  parameter int              PC_W     = 32,
  parameter int              INS_W    = 32,
  parameter int              OP_W     = 6,
  parameter int              N_OBS    = 3,
  parameter logic [63:0]     JMP_MASK = 64'h0000_070F_0000_0000,
  parameter logic [INS_W-1:0] NOP     = 32'hdc000000,
  parameter int              SHADOW   = 0,
  parameter int              CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rstd,
  input  logic                  stall_in,
  input  logic                  redirect_in,
  input  logic [N_OBS*OP_W-1:0] op_obs,
  input  logic                  valid_in,
  input  logic [PC_W-1:0]       pc_in,
  input  logic [INS_W-1:0]      ins_in,
  output logic [PC_W-1:0]       pc_out,
  output logic [INS_W-1:0]      ins_out,
  output logic                  valid_out,
  output logic                  flush_busy,
  output logic [CNT_W-1:0]      squash_cnt,
  output logic                  dbg_state
);

  typedef enum logic {S_RUN = 1'b0, S_SHADOW = 1'b1} state_t;

  localparam logic [3:0] SHADOW_V = 4'(SHADOW);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_shad;
  logic [3:0]       w_shad_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [INS_W-1:0] r_ins;
  logic             r_valid;
  logic [CNT_W-1:0] r_cnt;
  logic [OP_W-1:0]  w_op;
  logic             w_hit;
  logic             w_jump;
  logic             w_squash;

  // Opcodes at or above 64 have no mask bit and can never be jump-class.
  always_comb begin
    w_hit = 1'b0;
    w_op  = '0;
    for (int k = 0; k < N_OBS; k++) begin
      w_op = op_obs[k*OP_W +: OP_W];
      if ((w_op >> 6) == '0) w_hit = w_hit | JMP_MASK[6'(w_op)];
    end
  end

  assign w_jump   = w_hit | redirect_in;
  assign w_squash = w_jump | (r_state == S_SHADOW);

  always_comb begin
    w_state_nxt = r_state;
    w_shad_nxt  = r_shad;
    case (r_state)
      S_RUN: begin
        if (w_jump) w_shad_nxt = SHADOW_V;
        else if (r_shad != 4'd0) w_state_nxt = S_SHADOW;
      end
      S_SHADOW: begin
        if (w_jump) begin
          w_shad_nxt = SHADOW_V;
        end else if (!stall_in) begin
          w_shad_nxt = r_shad - 4'd1;
          if (r_shad == 4'd1) w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      r_state <= S_RUN;
      r_shad  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_shad  <= w_shad_nxt;
    end
  end

  // A bubble replaces even a held instruction; the PC still honours the stall.
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      r_pc    <= '0;
      r_ins   <= NOP;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (w_squash) begin
      if (!stall_in) r_pc <= pc_in;
      r_ins   <= NOP;
      r_valid <= 1'b0;
      if (valid_in && !stall_in && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end else if (!stall_in) begin
      r_pc    <= pc_in;
      r_ins   <= ins_in;
      r_valid <= valid_in;
    end
  end

  assign pc_out     = r_pc;
  assign ins_out    = r_ins;
  assign valid_out  = r_valid;
  assign squash_cnt = r_cnt;
  assign flush_busy = w_squash;
  assign dbg_state  = (r_state == S_SHADOW);

endmodule
